// File: rtl/uart_pkg.sv
// Shared UART definitions: standard baud divisor, frame width and the
// transmitter state encoding used by the TX datapath.
package uart_pkg;

  localparam int BAUD_DIV_115200 = 868;
  localparam int UART_DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO feeding the UART transmitter. Push is ignored when
// full and pop is ignored when empty, so callers may drive them freely.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      count_q, count_d;
  logic             pushEn;
  logic             popEn;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rdPtr_q];
  assign pushEn  = push_i & ~full_o;
  assign popEn   = pop_i & ~empty_o;

  // Next pointer and occupancy; a simultaneous push and pop keeps the count.
  always_comb begin
    wrPtr_d = pushEn ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = popEn  ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d = count_q;
    case ({pushEn, popEn})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset flushes the queue contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (pushEn) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with byte FIFO. The FSM pops a byte, sends start,
// eight data bits LSB first and a stop bit, and chains straight into the
// next frame while the FIFO holds data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_115200,
  parameter int FIFO_DEPTH = 16,
  localparam int CW        = $clog2(BAUD_DIV),
  localparam int NW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [UART_DATA_BITS-1:0] byte_in,
  input  logic                      byte_valid,
  output logic                      byte_ready,
  output logic                      tx,
  output logic                      busy,
  output logic [NW-1:0]             fifo_count
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_START = START;
  localparam logic [1:0] ST_DATA  = DATA;
  localparam logic [1:0] ST_STOP  = STOP;

  logic [1:0]                state_q, state_d;
  logic [CW-1:0]             baudCnt_q, baudCnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bitIdx_q, bitIdx_d;
  logic                      tx_q, tx_d;
  logic                      pop;
  logic                      bitEnd;
  logic [UART_DATA_BITS-1:0] fifoData;
  logic                      fifoFull;
  logic                      fifoEmpty;

  uart_tx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (byte_valid),
    .data_i  (byte_in),
    .pop_i   (pop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifo_count)
  );

  assign bitEnd     = (baudCnt_q == CW'(BAUD_DIV - 1));
  assign byte_ready = ~fifoFull;
  assign tx         = tx_q;
  assign busy       = (state_q != ST_IDLE) | (fifo_count != '0);

  // Frame sequencing: tx_d is the line level for the state being entered,
  // so the registered tx changes on the same edge as the state.
  always_comb begin
    state_d   = state_q;
    baudCnt_d = bitEnd ? '0 : baudCnt_q + 1'b1;
    shift_d   = shift_q;
    bitIdx_d  = bitIdx_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baudCnt_d = '0;
        tx_d      = 1'b1;
        if (!fifoEmpty) begin
          pop     = 1'b1;
          shift_d = fifoData;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end
      ST_START: begin
        if (bitEnd) begin
          state_d  = ST_DATA;
          bitIdx_d = '0;
          tx_d     = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bitEnd) begin
          if (bitIdx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            bitIdx_d = bitIdx_q + 1'b1;
            tx_d     = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (bitEnd) begin
          if (!fifoEmpty) begin
            pop     = 1'b1;
            shift_d = fifoData;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // State, baud counter, shift register and line register; reset idles the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      baudCnt_q <= '0;
      shift_q   <= '0;
      bitIdx_q  <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      shift_q   <= shift_d;
      bitIdx_q  <= bitIdx_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter with an internal byte FIFO, the transmit counterpart of the board's 8N1 serial receiver. Accepts bytes from the host-side logic via a valid/ready handshake, buffers up to FIFO_DEPTH bytes and serialises them on `tx` at 115200 baud from the 100 MHz system clock. Back-to-back frames are sent with no idle gap while the FIFO is non-empty.

## Interface
- `BAUD_DIV`, 868: clock cycles per bit (100 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, 16: FIFO entries. Power of two, ≥ 2.

- `clk`  in  1  system clock (100 MHz).
- `rst`  in  1  reset: `rst`, synchronous, active-high; clock `clk`.
- `byte_in`  in  8  byte to transmit.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  FIFO can accept; transfer occurs on a rising edge where `byte_valid & byte_ready`.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  FIFO non-empty or a frame in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  bytes held in FIFO (excludes the byte in the shift register).

## Operation
- Frame: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). No parity.
- FSM states:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop, load the shift register, clear the baud counter, and go to START.
  - START: `tx`=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx`=shift[0] for BAUD_DIV cycles per bit; shift right after each bit. After bit 7, go to STOP.
  - STOP: `tx`=1 for BAUD_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START; otherwise go to IDLE.
- Baud counter:
  - Width $clog2(BAUD_DIV). Counts 0..BAUD_DIV-1 and wraps to 0 on the bit boundary; no drift.
  - Runs only outside IDLE.
- FIFO:
  - `byte_ready` = !full.
  - A push and a pop in the same cycle leave `fifo_count` unchanged. A push while empty, together with a pop decision in the same cycle, is not possible: a pop requires non-empty in the current cycle.
  - Pointers wrap modulo FIFO_DEPTH. full = count==FIFO_DEPTH; empty = count==0.
- `busy` = (state != IDLE) | (fifo_count != 0).
- Reset mid-frame:
  - On the next edge, FSM goes to IDLE, `tx`=1, and the FIFO is flushed.
  - The partial frame is truncated. Downstream sees a framing error, which is accepted behaviour.

## Timing
- Reset values: `tx`=1, `byte_ready`=1, `busy`=0, `fifo_count`=0; internal shift register=0, baud counter=0.
- Latency: byte accepted at edge E0 into an empty FIFO while IDLE → pop at E1 → `tx` low from E1.
  - Start bit spans E1..E1+BAUD_DIV.
  - Data bit k spans E1+(k+1)·BAUD_DIV.
  - Stop bit ends at E1+10·BAUD_DIV.
- Frame period: exactly 10·BAUD_DIV cycles. Consecutive queued bytes produce a start bit immediately after the stop bit.
- `byte_ready` deasserts on the edge that makes the FIFO full. It reasserts on the edge of the next pop.
- `fifo_count` and `busy` are registered or derived from registers; no combinational path from `byte_valid`.

## Structure
- Shared package `uart_pkg`:
  - `BAUD_DIV_115200` = 868.
  - `UART_DATA_BITS` = 8.
  - State typedef `uart_tx_state_t` {IDLE, START, DATA, STOP}.
- Sub-module `uart_tx_fifo`: synchronous single-clock FIFO with push/pop/full/empty/count, parameterised by width and depth. The top level holds the FSM, baud counter and shift register.
- Expected size: 200–300 lines total.

## Test plan
- Single byte 0x55, BAUD_DIV=8:
  - `tx` sequence per 8-cycle bit is 0,1,0,1,0,1,0,1,0,1, starting one cycle after acceptance.
  - `busy` falls 80 cycles after `tx` first goes low.
- Back-to-back 0xA5, 0x3C pushed in consecutive cycles:
  - Two frames, 160 cycles total with no idle gap.
  - Data bits LSB first: 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
- Fill: hold `byte_valid` for 20 cycles with `byte_in` incrementing from 0x00, BAUD_DIV=8.
  - 17 bytes accepted: one popped immediately, 16 queued.
  - `byte_ready` low when `fifo_count`=16; byte 0x11 held until the next pop.
  - All accepted bytes are transmitted in order.
- Push and pop in the same cycle at `fifo_count`=3 → `fifo_count` stays 3.
- Reset asserted during data bit 4 → on the next edge, `tx`=1, `busy`=0, `fifo_count`=0; no further frames.
- Loopback into the existing receiver at BAUD_DIV=868 with bytes 0x00, 0xFF, 0x5A, 0x81 → receiver outputs an identical byte sequence.
